// File: rtl/ysyx_22041071_axi_rd_arb.sv
// Read-channel arbiter sharing one AXI read bridge between IF (requester 0) and MEM (requester 1).
// Define YSYX_22041071_ARB_RR_EN for round-robin; otherwise MEM wins ties.
module ysyx_22041071_axi_rd_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [LEN_W-1:0]  if_len,
  input  logic [1:0]        if_size,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic [1:0]        if_rsp_resp,
  output logic              if_rsp_last,
  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LEN_W-1:0]  mem_len,
  input  logic [1:0]        mem_size,
  output logic              mem_rsp_valid,
  output logic [DATA_W-1:0] mem_rsp_data,
  output logic [1:0]        mem_rsp_resp,
  output logic              mem_rsp_last,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  output logic [ID_W-1:0]   m_ar_id,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LEN_W-1:0]  m_len,
  output logic [1:0]        m_size,
  output logic              m_r_ready,
  input  logic              m_r_valid,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [1:0]        m_r_resp,
  input  logic              m_r_last,
  input  logic [ID_W-1:0]   m_r_id,
  output logic              arb_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        size_q, size_d;
  logic              owner_q, owner_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic gnt_if, gnt_mem;

`ifdef YSYX_22041071_ARB_RR_EN
  // last_grant_q: 0 = IF won last, 1 = MEM won last; the other side wins a tie.
  logic last_grant_q;

  assign gnt_mem = mem_req_valid & (~if_req_valid | ~last_grant_q);
  assign gnt_if  = if_req_valid & (~mem_req_valid | last_grant_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else if (mem_req_ready | if_req_ready) begin
      last_grant_q <= mem_req_ready;
    end
  end
`else
  assign gnt_mem = mem_req_valid;
  assign gnt_if  = if_req_valid & ~mem_req_valid;
`endif

  logic            accept;
  logic            beat;
  logic            id_bad;
  logic [ID_W-1:0] owner_id;
  logic [1:0]      routed_resp;

  assign if_req_ready  = (state_q == S_IDLE) & gnt_if;
  assign mem_req_ready = (state_q == S_IDLE) & gnt_mem;
  assign accept        = if_req_ready | mem_req_ready;

  assign owner_id    = ID_W'(owner_q);
  assign beat        = (state_q == S_DATA) & m_r_valid;
  assign id_bad      = (m_r_id != owner_id);
  assign routed_resp = id_bad ? 2'b10 : m_r_resp;

  // Response fields are zeroed for the non-owner so idle outputs stay at 0.
  assign if_rsp_valid  = beat & ~owner_q;
  assign if_rsp_data   = if_rsp_valid ? m_r_data : '0;
  assign if_rsp_resp   = if_rsp_valid ? routed_resp : 2'b00;
  assign if_rsp_last   = if_rsp_valid & m_r_last;
  assign mem_rsp_valid = beat & owner_q;
  assign mem_rsp_data  = mem_rsp_valid ? m_r_data : '0;
  assign mem_rsp_resp  = mem_rsp_valid ? routed_resp : 2'b00;
  assign mem_rsp_last  = mem_rsp_valid & m_r_last;

  assign m_ar_valid = ar_valid_q;
  assign m_ar_id    = owner_id;
  assign m_addr     = addr_q;
  assign m_len      = len_q;
  assign m_size     = size_q;
  assign m_r_ready  = (state_q == S_DATA);
  assign arb_err    = err_q;

  always_comb begin
    state_d    = state_q;
    ar_valid_d = ar_valid_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d     = mem_req_ready ? mem_addr : if_addr;
          len_d      = mem_req_ready ? mem_len  : if_len;
          size_d     = mem_req_ready ? mem_size : if_size;
          owner_d    = mem_req_ready;
          cnt_d      = '0;
          ar_valid_d = 1'b1;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ar_valid_q && m_ar_ready) begin
          ar_valid_d = 1'b0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (m_r_valid) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (id_bad) err_d = 1'b1;
          // Length mismatches are flagged, but only m_r_last ends the burst.
          if (m_r_last) begin
            if (cnt_q != len_q) err_d = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_q == len_q) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ar_valid_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= 2'b00;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_valid_q <= ar_valid_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// Directed bench for ysyx_22041071_axi_rd_arb: request, AR handshake, beat routing and error flag.
module tb_ysyx_22041071_axi_rd_arb;

`ifdef YSYX_22041071_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0, mem_req_valid = 1'b0;
  logic        if_req_ready, mem_req_ready;
  logic [63:0] if_addr = '0, mem_addr = '0;
  logic [7:0]  if_len = '0, mem_len = '0;
  logic [1:0]  if_size = '0, mem_size = '0;
  logic        if_rsp_valid, mem_rsp_valid;
  logic [63:0] if_rsp_data, mem_rsp_data;
  logic [1:0]  if_rsp_resp, mem_rsp_resp;
  logic        if_rsp_last, mem_rsp_last;
  logic        m_ar_valid;
  logic        m_ar_ready = 1'b0;
  logic [3:0]  m_ar_id;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  logic [1:0]  m_size;
  logic        m_r_ready;
  logic        m_r_valid = 1'b0;
  logic [63:0] m_r_data = '0;
  logic [1:0]  m_r_resp = '0;
  logic        m_r_last = 1'b0;
  logic [3:0]  m_r_id = '0;
  logic        arb_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22041071_axi_rd_arb dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_addr(if_addr), .if_len(if_len), .if_size(if_size),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .if_rsp_resp(if_rsp_resp), .if_rsp_last(if_rsp_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_size(mem_size),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_resp(mem_rsp_resp), .mem_rsp_last(mem_rsp_last),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_addr(m_addr), .m_len(m_len), .m_size(m_size),
    .m_r_ready(m_r_ready), .m_r_valid(m_r_valid), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_id(m_r_id),
    .arb_err(arb_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Raise one requester, check its grant, then walk the AR phase with ar_delay wait cycles.
  task automatic issue(input bit who, input logic [63:0] a, input logic [7:0] l,
                       input logic [1:0] s, input int ar_delay);
    if (who) begin
      mem_req_valid = 1'b1; mem_addr = a; mem_len = l; mem_size = s;
    end else begin
      if_req_valid = 1'b1; if_addr = a; if_len = l; if_size = s;
    end
    #1;
    check("req_ready", who ? mem_req_ready : if_req_ready, 1);
    check("other_ready", who ? if_req_ready : mem_req_ready, 0);
    tick();
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    if_addr = '1; mem_addr = '1; if_len = 8'hff; mem_len = 8'hff; if_size = 2'b01; mem_size = 2'b01;
    #1;
    check("ready_drop", {if_req_ready, mem_req_ready}, 0);
    for (int i = 0; i <= ar_delay; i++) begin
      check("ar_valid", m_ar_valid, 1);
      check("ar_id", m_ar_id, who ? 64'd1 : 64'd0);
      check("ar_addr", m_addr, a);
      check("ar_len", m_len, l);
      check("ar_size", m_size, s);
      if (i == ar_delay) m_ar_ready = 1'b1;
      tick();
    end
    m_ar_ready = 1'b0;
    #1;
    check("ar_valid_drop", m_ar_valid, 0);
    check("r_ready", m_r_ready, 1);
  endtask

  task automatic beat(input bit who, input logic [63:0] d, input logic [1:0] r, input bit last,
                      input logic [3:0] id, input logic [1:0] exp_resp);
    m_r_valid = 1'b1; m_r_data = d; m_r_resp = r; m_r_last = last; m_r_id = id;
    #1;
    check("rsp_valid", who ? mem_rsp_valid : if_rsp_valid, 1);
    check("rsp_data", who ? mem_rsp_data : if_rsp_data, d);
    check("rsp_resp", who ? mem_rsp_resp : if_rsp_resp, exp_resp);
    check("rsp_last", who ? mem_rsp_last : if_rsp_last, last);
    check("nonowner_valid", who ? if_rsp_valid : mem_rsp_valid, 0);
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_ar_valid", m_ar_valid, 0);
    check("rst_ar_id", m_ar_id, 0);
    check("rst_addr", m_addr, 0);
    check("rst_len", m_len, 0);
    check("rst_size", m_size, 0);
    check("rst_r_ready", m_r_ready, 0);
    check("rst_ready", {if_req_ready, mem_req_ready}, 0);
    check("rst_rsp", {if_rsp_valid, mem_rsp_valid, if_rsp_last, mem_rsp_last}, 0);
    check("rst_err", arb_err, 0);
    do_reset();

    // Single IF read
    issue(1'b0, 64'h8000_0000, 8'd0, 2'b11, 0);
    beat(1'b0, 64'h1122334455667788, 2'b00, 1'b1, 4'd0, 2'b00);
    #1;
    check("t1_rsp_gone", {if_rsp_valid, mem_rsp_valid}, 0);
    check("t1_idle", m_r_ready, 0);
    check("t1_err", arb_err, 0);

    // Tie: MEM first, IF accepted in the IDLE cycle after MEM's last beat
    if_req_valid = 1'b1; if_addr = 64'h8000_0100; if_len = 8'd0; if_size = 2'b11;
    mem_req_valid = 1'b1; mem_addr = 64'h0000_2000; mem_len = 8'd0; mem_size = 2'b11;
    #1;
    check("tie_mem_ready", mem_req_ready, 1);
    check("tie_if_ready", if_req_ready, 0);
    tick();
    mem_req_valid = 1'b0;
    #1;
    check("tie_ar_id", m_ar_id, 1);
    check("tie_addr", m_addr, 64'h0000_2000);
    check("tie_if_wait", if_req_ready, 0);
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0;
    beat(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 1'b1, 4'd1, 2'b00);
    issue(1'b0, 64'h8000_0100, 8'd0, 2'b11, 0);
    beat(1'b0, 64'h0102030405060708, 2'b00, 1'b1, 4'd0, 2'b00);

    // Both held valid: the second tie goes to IF only under round-robin
    if_req_valid = 1'b1; mem_req_valid = 1'b1;
    mem_addr = 64'h3000; mem_len = 8'd0; mem_size = 2'b10;
    #1;
    check("tie2_mem_ready", mem_req_ready, 1);
    tick();
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0;
    beat(1'b1, 64'h55, 2'b00, 1'b1, 4'd1, 2'b00);
    #1;
    check("tie2_if_ready", if_req_ready, RR ? 1 : 0);
    check("tie2_mem_ready2", mem_req_ready, RR ? 0 : 1);
    issue(RR ? 1'b0 : 1'b1, 64'h4000, 8'd0, 2'b10, 0);
    beat(RR ? 1'b0 : 1'b1, 64'h66, 2'b00, 1'b1, RR ? 4'd0 : 4'd1, 2'b00);

    // MEM burst len=3 with delayed AR ready; requester inputs scrambled while held
    issue(1'b1, 64'h0000_1000, 8'd3, 2'b11, 4);
    for (int i = 0; i < 4; i++)
      beat(1'b1, 64'hD000 + 64'(i), (i == 2) ? 2'b01 : 2'b00, i == 3, 4'd1,
           (i == 2) ? 2'b01 : 2'b00);
    check("burst_err", arb_err, 0);

    // Reset during DATA after the first of four beats
    issue(1'b1, 64'h0000_5000, 8'd3, 2'b11, 0);
    beat(1'b1, 64'hE0, 2'b00, 1'b0, 4'd1, 2'b00);
    m_r_valid = 1'b1; m_r_id = 4'd1; m_r_data = 64'hE1;
    reset = 1'b1;
    #1;
    check("mid_rst_rsp", {mem_rsp_valid, if_rsp_valid}, 0);
    check("mid_rst_r_ready", m_r_ready, 0);
    check("mid_rst_addr", m_addr, 0);
    check("mid_rst_len", m_len, 0);
    check("mid_rst_ar", {m_ar_valid, m_ar_id}, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_rsp", {mem_rsp_valid, if_rsp_valid}, 0);
    check("post_rst_err", arb_err, 0);
    m_r_valid = 1'b0;

    // Wrong ID on an IF beat
    issue(1'b0, 64'h8000_0200, 8'd0, 2'b11, 0);
    beat(1'b0, 64'h77, 2'b00, 1'b1, 4'd1, 2'b10);
    check("id_err", arb_err, 1);
    do_reset();

    // Early last: len=3, last on beat 2
    issue(1'b0, 64'h8000_0300, 8'd3, 2'b11, 0);
    beat(1'b0, 64'h10, 2'b00, 1'b0, 4'd0, 2'b00);
    check("early_err_before", arb_err, 0);
    beat(1'b0, 64'h11, 2'b00, 1'b1, 4'd0, 2'b00);
    check("early_err", arb_err, 1);
    check("early_idle", m_r_ready, 0);
    issue(1'b1, 64'h6000, 8'd0, 2'b11, 0);
    beat(1'b1, 64'h12, 2'b00, 1'b1, 4'd1, 2'b00);
    check("err_sticky", arb_err, 1);
    do_reset();

    // Counter reaches len without last
    issue(1'b1, 64'h7000, 8'd0, 2'b11, 0);
    beat(1'b1, 64'h20, 2'b00, 1'b0, 4'd1, 2'b00);
    check("nolast_err", arb_err, 1);
    check("nolast_busy", m_r_ready, 1);
    beat(1'b1, 64'h21, 2'b00, 1'b1, 4'd1, 2'b00);
    check("nolast_idle", m_r_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_axi_rd_arb.md
Name: ysyx_22041071_axi_rd_arb

Overview:
- Two-requester arbiter in front of the single AXI read-channel bridge.
- Shares it between instruction fetch (IF, requester 0) and load unit (MEM, requester 1).
- Grants one read transaction at a time, holds the request stable through the AR handshake, and routes R beats back to the owner.
- Counts beats against the granted length and flags protocol mismatches.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, read data width
- LEN_W, 8, burst length field width (beats = len+1)
- ID_W, 4, transaction ID width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- if_req_valid / mem_req_valid  in  1  read request
- if_req_ready / mem_req_ready  out  1  request accepted this cycle
- if_addr / mem_addr  in  ADDR_W  request address
- if_len / mem_len  in  LEN_W  burst length
- if_size / mem_size  in  2  00=1B, 01=2B, 10=4B, 11=8B
- if_rsp_valid / mem_rsp_valid  out  1  response beat
- if_rsp_data / mem_rsp_data  out  DATA_W  beat data
- if_rsp_resp / mem_rsp_resp  out  2  beat response
- if_rsp_last / mem_rsp_last  out  1  final beat
- m_ar_valid  out  1  to bridge
- m_ar_ready  in  1  from bridge
- m_ar_id  out  ID_W  transaction ID
- m_addr  out  ADDR_W  address to bridge
- m_len  out  LEN_W  burst length to bridge
- m_size  out  2  transfer size to bridge
- m_r_ready  out  1  read data ready
- m_r_valid  in  1  read data valid
- m_r_data  in  DATA_W  read data
- m_r_resp  in  2  read response
- m_r_last  in  1  last read beat
- m_r_id  in  ID_W  read beat ID
- arb_err  out  1  sticky protocol error

Behaviour:
- States: IDLE, ADDR, DATA. Async reset -> IDLE.
- Reset values:
  - m_ar_valid=0, m_ar_id=0, m_addr=0, m_len=0, m_size=0.
  - owner=0, beat counter=0, arb_err=0.
  - All rsp outputs 0, all req_ready 0, m_r_ready=0.
- IDLE:
  - Combinational grant among valid requesters; X_req_ready = (state==IDLE) & grant[X].
  - On handshake: latch addr/len/size, set owner, m_ar_id={zeros, owner}, clear beat counter; next state ADDR.
- ADDR:
  - m_ar_valid=1 (registered; first high the cycle after acceptance).
  - Request fields held constant regardless of requester inputs.
  - On m_ar_valid & m_ar_ready: m_ar_valid drops next cycle; next state DATA.
- DATA:
  - m_r_ready=1. Requesters always accept beats; no backpressure.
  - Owner's rsp_valid = m_r_valid (combinational); data, resp and last pass through.
  - Non-owner rsp_valid=0.
  - If m_r_id != owner ID, the routed rsp_resp is forced to 2'b10 and arb_err is set.
  - Beat counter increments per beat.
  - Exit to IDLE on m_r_valid & m_r_last.
  - If last arrives with counter != latched len, or counter reaches len without last, set arb_err.
  - Transaction still terminates only on m_r_last.
- Arbitration (default): fixed priority, MEM over IF.
- Throughput:
  - The cycle after the last beat is IDLE, and a new request may be accepted in that cycle.
  - Minimum 1 cycle from last beat to next acceptance.
  - Minimum 1 cycle from acceptance to m_ar_valid.
- arb_err is cleared only by reset.
- Reset mid-operation: returns to IDLE immediately; in-flight beats are discarded and no rsp_valid is raised.
- Requester dropping req_valid while not granted is legal; nothing is latched.

Optional Feature:
- Macro YSYX_22041071_ARB_RR_EN.
- Defined: round-robin. A 1-bit last-grant register (reset 0 = IF) is updated on each acceptance; on simultaneous requests the requester not granted last wins.
- Undefined: fixed priority, MEM always wins ties; no last-grant register is present.

Test Plan:
- Single IF request, addr=0x8000_0000, len=0, size=11; bridge returns data=0x1122334455667788, resp=0, last=1:
  - if_req_ready high 1 cycle.
  - m_ar_valid next cycle with m_ar_id=0.
  - if_rsp_valid 1 cycle with that data.
  - mem_rsp_valid stays 0.
- IF and MEM both valid in the same cycle, fixed priority:
  - MEM is granted first with m_ar_id=1.
  - IF is accepted in the IDLE cycle after MEM's last beat.
  - With RR_EN, a repeat of the tie grants IF next.
- MEM burst len=3, m_ar_ready delayed 4 cycles:
  - m_addr/m_len are held stable throughout.
  - 4 beats route to mem_rsp; mem_rsp_last on beat 4.
  - arb_err stays 0.
- Burst len=3 but m_r_last asserted on beat 2 -> return to IDLE, arb_err=1 and remains set.
- Owner IF, beat arrives with m_r_id=1 -> if_rsp_resp=2'b10, arb_err=1.
- Reset asserted during DATA after beat 1 of 4 -> outputs return to their reset values asynchronously, state IDLE, no further rsp_valid.
